// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: digit count, blank codes
// and the active-low hex segment table.
`timescale 1ns/1ps
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low patterns {dp,g,f,e,d,c,b,a} with dp held off; entry n is digit n.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder (dp excluded).
`timescale 1ns/1ps
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble][6:0];

endmodule

// File: rtl/seg_scan.sv
// Multiplexed eight-digit hex display driver. A new value is taken into a
// pending slot by valid/ready handshake and promoted to the display register
// only at a frame boundary, so a frame never shows two different values.
`timescale 1ns/1ps
module seg_scan #(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = seg_pkg::NUM_DIGITS
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              Segment,
  output logic                    frame_done
);

  import seg_pkg::*;

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic                      pend_full;
  logic [4*NUM_DIGITS-1:0]   pend;
  logic [4*NUM_DIGITS-1:0]   disp;
  logic                      ready_q;

  logic                      wrap;
  logic                      boundary;
  logic                      capture;
  logic                      pend_full_next;
  logic [3:0]                nibble;
  logic [6:0]                seg7;
  logic                      blank;
  logic [NUM_DIGITS-1:0]     an_active;

  assign wrap           = (cnt == CNT_MAX);
  assign boundary       = wrap && (idx == IDX_MAX);
  assign capture        = value_valid && ready_q;
  // The slot stays occupied until the boundary that empties it; a capture on
  // that same edge refills it immediately.
  assign pend_full_next = capture || (pend_full && !boundary);

  assign value_ready = ready_q;
  // Gated by RST so that asserting reset on a boundary cycle never pulses.
  assign frame_done  = boundary && !RST;

  // Dwell counter and digit index; the index steps once per completed dwell.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every process
    // sees the pre-edge value of cnt/idx regardless of evaluation order.
    if (RST) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Handshake state and display register; promotion happens only at a boundary.
  always_ff @(posedge clk) begin
    if (RST) begin
      pend_full <= 1'b0;
      disp      <= '0;
      ready_q   <= 1'b0;
    end else begin
      if (boundary && pend_full) disp <= pend;
      pend_full <= pend_full_next;
      ready_q   <= !pend_full_next;
    end
  end

  // Pending data word, loaded on an accepted handshake.
  always_ff @(posedge clk) begin
    // NOTE: no reset on this data register; its contents are only consumed
    // while pend_full is set, and pend_full itself is reset.
    if (capture) pend <= value;
  end

  // Selected nibble and leading-zero decision for the current digit.
  always_comb begin
    nibble    = disp[{idx, 2'b00} +: 4];
    blank     = blank_lz && (idx != '0) && ((disp >> {idx, 2'b00}) == '0);
    an_active = ~(NUM_DIGITS'(1) << idx);
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (seg7)
  );

  // Registered anode and segment drive, one cycle behind the digit index.
  always_ff @(posedge clk) begin
    if (RST || blank) begin
      AN      <= AN_OFF;
      Segment <= SEG_BLANK;
    end else begin
      AN      <= an_active;
      Segment <= {~dp_mask[idx], seg7};
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Randomized scoreboard bench for seg_scan with SCAN_DIV = 4. A frame-level
// reference model predicts outputs from the edge count since reset release.
`timescale 1ns/1ps
module tb_seg_scan;

  localparam int SCAN_DIV = 4;
  localparam int DWELL    = SCAN_DIV;
  localparam int FRAME    = 8 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] value = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [7:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  AN;
  logic [7:0]  Segment;
  logic        frame_done;

  seg_scan #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(8)) dut (
    .clk         (clk),
    .RST         (RST),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .dp_mask     (dp_mask),
    .blank_lz    (blank_lz),
    .AN          (AN),
    .Segment     (Segment),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: edges since release, one pending slot, display word.
  int          e = -1;
  bit          m_pf = 1'b0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_disp = '0;
  bit          m_rdy = 1'b0;
  bit          m_acc = 1'b0;

  logic [7:0]  cur_dp  = '0;
  logic        cur_blz = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [31:0] val,
                            input logic [7:0] dp, input logic b);
    exp_t x;
    int d;
    logic [3:0] nib;
    m_acc = 1'b0;
    if (r) begin
      e = -1; m_pf = 1'b0; m_disp = '0; m_rdy = 1'b0;
      x.an = 8'hFF; x.seg = 8'hFF; x.fd = 1'b0; x.rdy = 1'b0;
    end else begin
      e++;
      d   = (e / DWELL) % 8;
      nib = m_disp[4*d +: 4];
      if (b && d != 0 && (m_disp >> (4*d)) == 32'h0) begin
        x.an = 8'hFF; x.seg = 8'hFF;
      end else begin
        x.an  = 8'hFF ^ (8'h01 << d);
        x.seg = {~dp[d], hex_tab[nib][6:0]};
      end
      m_acc = v && m_rdy;
      if (e % FRAME == FRAME - 1 && m_pf) begin
        m_disp = m_pend; m_pf = 1'b0;
      end
      if (m_acc) begin
        m_pend = val; m_pf = 1'b1;
      end
      m_rdy = !m_pf;
      x.fd  = (e % FRAME == FRAME - 2);
      x.rdy = m_rdy;
    end
    sb.push_back(x);
  endtask

  task automatic tick(input logic r, input logic v, input logic [31:0] val);
    @(negedge clk); #1;
    RST = r; value_valid = v; value = val; dp_mask = cur_dp; blank_lz = cur_blz;
    @(posedge clk);
    model_edge(r, v, val, cur_dp, cur_blz);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, $urandom);
  endtask

  task automatic load(input logic [31:0] val);
    bit done = 1'b0;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      tick(1'b0, 1'b1, val);
      done = m_acc;
    end
    if (!done) check("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_until(input int phase);
    for (int i = 0; i < 2 * FRAME && (e % FRAME) != phase; i++) idle(1);
  endtask

  // Monitor: every cycle the DUT presents a registered output set; compare it.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("AN",          32'(AN),          32'(x.an));
        check("Segment",     32'(Segment),     32'(x.seg));
        check("frame_done",  32'(frame_done),  32'(x.fd));
        check("value_ready", 32'(value_ready), 32'(x.rdy));
      end
    end
  end

  initial begin
    // Reset and release, then a plain load shown for several frames.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
    idle(2);
    load(32'h12345678);
    idle(2 * FRAME + 5);

    // Back-to-back loads with valid held; the second waits for the boundary.
    cur_dp = 8'h00;
    load(32'hAAAAAAAA);
    load(32'h55555555);
    idle(2 * FRAME);

    // Leading-zero blanking.
    cur_blz = 1'b1;
    load(32'h000000F0);
    idle(2 * FRAME);
    cur_dp = 8'h81;
    load(32'h00000000);
    idle(2 * FRAME);

    // Reset in the middle of digit 5 with a value pending.
    cur_dp = 8'h00; cur_blz = 1'b0;
    load(32'hDEADBEEF);
    idle(FRAME + 3);
    idle_until(0);
    load(32'hCAFE0123);
    idle_until(5 * DWELL + 1);
    tick(1'b1, 1'b0, '0);
    idle(FRAME + 8);

    // Randomized traffic with occasional reset and live mask changes.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) cur_dp = 8'($urandom);
      if ($urandom_range(0, 149) == 0) cur_blz = ~cur_blz;
      if ($urandom_range(0, 399) == 0)
        tick(1'b1, 1'b0, $urandom);
      else
        tick(1'b0, 1'($urandom_range(0, 9) == 0),
             32'($urandom) >> (4 * $urandom_range(0, 8)));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles each digit is driven (dwell); legal range 2..2^20.
REQ-002 Parameter NUM_DIGITS, default 8, digit count; fixed at 8 in this revision.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 value  input  32  hex word to display; digit i shows value[4i+3:4i].
REQ-006 value_valid  input  1  load request for value.
REQ-007 value_ready  output  1  high when a new value can be accepted.
REQ-008 dp_mask  input  8  bit i high lights decimal point of digit i; sampled live, not shadowed.
REQ-009 blank_lz  input  1  high enables leading-zero blanking.
REQ-010 AN  output  8  digit enables, active-low, bit i = digit i.
REQ-011 Segment  output  8  segment drive, active-low, order {dp,g,f,e,d,c,b,a}.
REQ-012 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Load handshake: value is captured into a pending register on any clk edge where value_valid and value_ready are both high.
REQ-014 value_ready shall be low from the cycle after a capture until the cycle after the next frame boundary, and high otherwise.
REQ-015 value_valid while value_ready is low is ignored; no value is queued or lost-tracked.
REQ-016 Dwell counter counts 0..SCAN_DIV-1 and wraps to 0; on the wrap cycle the digit index advances 0,1,...,7,0.
REQ-017 Frame boundary is the wrap cycle with digit index 7; on it the pending register (if full) transfers to the display register and frame_done pulses high for exactly that cycle.
REQ-018 The display register changes only at a frame boundary; no frame ever mixes two values.
REQ-019 AN and Segment are registered: they reflect the digit index one cycle after the index changes.
REQ-020 Active digit i: AN = all ones except bit i low; Segment[6:0] = hex pattern of nibble i; Segment[7] = ~dp_mask[i].
REQ-021 Hex patterns (dp bit high): 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E.
REQ-022 Leading-zero blanking: when blank_lz is high, digit i (i>=1) is blank if nibble i and all higher nibbles are zero; digit 0 is never blank.
REQ-023 A blank digit drives AN = 8'hFF and Segment = 8'hFF for its whole dwell, dp_mask notwithstanding.
REQ-024 Exactly one AN bit is low at any time outside reset and blank dwells.

Reset
REQ-025 While RST is high: dwell counter 0, digit index 0, pending empty, display register 32'h0, AN = 8'hFF, Segment = 8'hFF, frame_done = 0, value_ready = 0.
REQ-026 First clk edge after RST falls: value_ready = 1 and digit 0 of display register (0 -> Segment C0) is driven.
REQ-027 RST asserted mid-dwell or mid-frame discards pending and display contents; no frame_done is generated by the reset.

Structure
REQ-028 Shared package seg_pkg holds NUM_DIGITS, the 16-entry hex segment table, and constants SEG_BLANK = 8'hFF and AN_OFF = 8'hFF.
REQ-029 One combinational sub-module hex7seg (nibble in, 7-bit active-low pattern out) is instantiated once on the selected nibble.
REQ-030 Dwell counter width is derived from SCAN_DIV; no hard-coded width.

Verification (SCAN_DIV=4)
REQ-031 Reset released, value 32'h12345678 loaded with valid for 1 cycle -> ready drops, after first frame_done digits 0..7 show 8'h80,F8,82,92,99,B0,A4,F9 with AN FE,FD,...,7F, 4 cycles each.
REQ-032 Load 32'hAAAAAAAA then immediately 32'h55555555 with valid held -> second load stalls until ready rises after frame_done; no frame mixes A and 5 digits.
REQ-033 blank_lz=1, value 32'h000000F0 -> digits 2..7 AN=FF, Segment=FF; digit 1 shows 8E, digit 0 shows C0.
REQ-034 blank_lz=1, value 0, dp_mask 8'h81 -> only digit 0 enabled, Segment 8'h40; digit 7 stays blank despite dp_mask.
REQ-035 RST pulsed at dwell count 2 of digit 5 with pending full -> next cycle AN=FF, Segment=FF, ready=0; after release display is 0, no frame_done until 32 cycles later.
